// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard sequencer bundle: pipe-side hazard sources in, pipe register controls out.
// The pipe drives the master side; the sequencer sits on the slave side.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1_idx;
    logic [4:0]       id_rs2_idx;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       ex_rd_idx;
    logic             ex_wben;
    logic             ex_is_load;
    logic             ex_redirect;
    logic             ex_mdu_req;
    logic             mdu_done;
    logic             lsu_req;
    logic             lsu_ack;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_stall_n;
    logic             idex_flush;
    logic             idex_hold;
    logic             exmem_bubble;
    logic             memwb_en;
    logic [1:0]       state_o;
    logic             mdu_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used,
        output ex_rd_idx, ex_wben, ex_is_load, ex_redirect,
        output ex_mdu_req, mdu_done, lsu_req, lsu_ack,
        input  pc_en, ifid_en, ifid_flush, idex_stall_n,
        input  idex_flush, idex_hold, exmem_bubble, memwb_en,
        input  state_o, mdu_timeout, stall_cnt
    );

    modport slave (
        input  id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used,
        input  ex_rd_idx, ex_wben, ex_is_load, ex_redirect,
        input  ex_mdu_req, mdu_done, lsu_req, lsu_ack,
        output pc_en, ifid_en, ifid_flush, idex_stall_n,
        output idex_flush, idex_hold, exmem_bubble, memwb_en,
        output state_o, mdu_timeout, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use, redirects,
// multi-cycle MDU ops and LSU wait states, plus MDU watchdog and stall counter.
module pipe_hazard_ctrl #(
    parameter int MDU_MAX_CYC = 64,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        MEM_WAIT = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_stall_n;
        logic idex_flush;
        logic idex_hold;
        logic exmem_bubble;
        logic memwb_en;
    } ctl_t;

    localparam ctl_t CTL_NORM = '{
        pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_stall_n: 1'b1,
        idex_flush: 1'b0, idex_hold: 1'b0, exmem_bubble: 1'b0, memwb_en: 1'b1
    };
    localparam ctl_t CTL_MEMW = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_stall_n: 1'b0,
        idex_flush: 1'b0, idex_hold: 1'b1, exmem_bubble: 1'b0, memwb_en: 1'b0
    };
    localparam ctl_t CTL_REDIR = '{
        pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_stall_n: 1'b0,
        idex_flush: 1'b1, idex_hold: 1'b0, exmem_bubble: 1'b0, memwb_en: 1'b1
    };
    // EX stays frozen in ID/EX; EX/MEM gets bubbles while older ops drain
    localparam ctl_t CTL_MDU = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_stall_n: 1'b1,
        idex_flush: 1'b0, idex_hold: 1'b1, exmem_bubble: 1'b1, memwb_en: 1'b1
    };
    localparam ctl_t CTL_LDU = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_stall_n: 1'b0,
        idex_flush: 1'b0, idex_hold: 1'b0, exmem_bubble: 1'b0, memwb_en: 1'b1
    };

    localparam int              WD_W    = $clog2(MDU_MAX_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MDU_MAX_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_MAX_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    state_t           run_nxt;
    ctl_t             ctl;
    ctl_t             run_ctl;
    logic [WD_W-1:0]  wdog;
    logic             timeout_q;
    logic [CNT_W-1:0] cnt;

    logic rs1_hit;
    logic rs2_hit;
    logic ldu;
    logic memw;
    logic mdu_busy;

    assign rs1_hit  = hz.id_rs1_used & (hz.id_rs1_idx == hz.ex_rd_idx);
    assign rs2_hit  = hz.id_rs2_used & (hz.id_rs2_idx == hz.ex_rd_idx);
    assign ldu      = hz.ex_is_load & hz.ex_wben & (hz.ex_rd_idx != 5'd0)
                    & (rs1_hit | rs2_hit);
    assign memw     = hz.lsu_req & ~hz.lsu_ack;
    assign mdu_busy = hz.ex_mdu_req & ~hz.mdu_done;

    // RUN priority chain; also reused by MEM_WAIT on the ack cycle
    always_comb begin
        run_ctl = CTL_NORM;
        run_nxt = RUN;
        if (memw) begin
            run_ctl = CTL_MEMW;
            run_nxt = MEM_WAIT;
        end else if (hz.ex_redirect) begin
            run_ctl = CTL_REDIR;
        end else if (mdu_busy) begin
            run_ctl = CTL_MDU;
            run_nxt = MDU_WAIT;
        end else if (ldu) begin
            run_ctl = CTL_LDU;
        end
    end

    always_comb begin
        ctl       = CTL_NORM;
        state_nxt = RUN;
        unique case (state)
            RUN: begin
                ctl       = run_ctl;
                state_nxt = run_nxt;
            end
            MDU_WAIT: begin
                if (hz.mdu_done) begin
                    ctl       = CTL_NORM;
                    state_nxt = RUN;
                end else begin
                    ctl       = CTL_MDU;
                    state_nxt = MDU_WAIT;
                end
            end
            MEM_WAIT: begin
                if (hz.lsu_ack) begin
                    ctl       = run_ctl;
                    state_nxt = run_nxt;
                end else begin
                    ctl       = CTL_MEMW;
                    state_nxt = MEM_WAIT;
                end
            end
            default: begin
                ctl       = CTL_NORM;
                state_nxt = RUN;
            end
        endcase
        ctl.idex_hold = ctl.idex_hold & ~ctl.idex_flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wdog      <= '0;
            timeout_q <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            if (!ctl.pc_en) begin
                cnt <= cnt + CNT_W'(1);
            end
            // watchdog saturates at the limit; the flag is sticky until reset
            if (state == MDU_WAIT && !hz.mdu_done) begin
                if (wdog != WD_MAX) begin
                    wdog <= wdog + WD_W'(1);
                end
                if (wdog == WD_LAST) begin
                    timeout_q <= 1'b1;
                end
            end else begin
                wdog <= '0;
            end
        end
    end

    assign hz.pc_en        = ctl.pc_en;
    assign hz.ifid_en      = ctl.ifid_en;
    assign hz.ifid_flush   = ctl.ifid_flush;
    assign hz.idex_stall_n = ctl.idex_stall_n;
    assign hz.idex_flush   = ctl.idex_flush;
    assign hz.idex_hold    = ctl.idex_hold;
    assign hz.exmem_bubble = ctl.exmem_bubble;
    assign hz.memwb_en     = ctl.memwb_en;
    assign hz.state_o      = state;
    assign hz.mdu_timeout  = timeout_q;
    assign hz.stall_cnt    = cnt;

    a_flush_hold_excl: assert property (
        @(posedge clk) disable iff (rst)
        !(hz.idex_flush && hz.idex_hold)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a per-cycle rule model.
// Small MDU limit and a 4-bit stall counter expose timeout and wrap quickly.
module tb_pipe_hazard_ctrl;

    localparam int MAXC = 4;
    localparam int CW   = 4;

    localparam bit [7:0] C_NORM  = 8'b1101_0001;
    localparam bit [7:0] C_MEMW  = 8'b0000_0100;
    localparam bit [7:0] C_REDIR = 8'b1110_1001;
    localparam bit [7:0] C_MDU   = 8'b0001_0111;
    localparam bit [7:0] C_LDU   = 8'b0000_0001;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_idx, id_rs2_idx, ex_rd_idx;
    logic       id_rs1_used, id_rs2_used, ex_wben, ex_is_load;
    logic       ex_redirect, ex_mdu_req, mdu_done, lsu_req, lsu_ack;

    int checks   = 0;
    int failures = 0;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    assign hz.id_rs1_idx  = id_rs1_idx;
    assign hz.id_rs2_idx  = id_rs2_idx;
    assign hz.id_rs1_used = id_rs1_used;
    assign hz.id_rs2_used = id_rs2_used;
    assign hz.ex_rd_idx   = ex_rd_idx;
    assign hz.ex_wben     = ex_wben;
    assign hz.ex_is_load  = ex_is_load;
    assign hz.ex_redirect = ex_redirect;
    assign hz.ex_mdu_req  = ex_mdu_req;
    assign hz.mdu_done    = mdu_done;
    assign hz.lsu_req     = lsu_req;
    assign hz.lsu_ack     = lsu_ack;

    pipe_hazard_ctrl #(.MDU_MAX_CYC(MAXC), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] dut_ctl;
    assign dut_ctl = {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_stall_n,
                      hz.idex_flush, hz.idex_hold, hz.exmem_bubble, hz.memwb_en};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- rule model ----------------
    int m_mode = 0, m_cnt = 0, m_wd = 0;
    bit m_to = 0;
    int n_mode = 0, n_cnt = 0, n_wd = 0;
    bit n_to = 0;

    function automatic bit load_use();
        if (!(ex_is_load && ex_wben) || ex_rd_idx == 5'd0) return 1'b0;
        return (id_rs1_used && id_rs1_idx == ex_rd_idx) ||
               (id_rs2_used && id_rs2_idx == ex_rd_idx);
    endfunction

    function automatic void run_rules(output bit [7:0] o, output int nm);
        nm = 0;
        if (lsu_req && !lsu_ack) begin
            o  = C_MEMW;
            nm = 2;
        end else if (ex_redirect) begin
            o = C_REDIR;
        end else if (ex_mdu_req && !mdu_done) begin
            o  = C_MDU;
            nm = 1;
        end else if (load_use()) begin
            o = C_LDU;
        end else begin
            o = C_NORM;
        end
    endfunction

    always @(negedge clk) begin
        bit [7:0] e;
        int nm;
        if (!rst) begin
            case (m_mode)
                1: begin
                    e  = mdu_done ? C_NORM : C_MDU;
                    nm = mdu_done ? 0 : 1;
                end
                2: begin
                    if (lsu_ack) run_rules(e, nm);
                    else begin
                        e  = C_MEMW;
                        nm = 2;
                    end
                end
                default: run_rules(e, nm);
            endcase
            chk("m_ctl", dut_ctl, e);
            chk("m_state", hz.state_o, m_mode);
            chk("m_timeout", hz.mdu_timeout, m_to);
            chk("m_stall_cnt", hz.stall_cnt, m_cnt);
            n_mode = nm;
            n_cnt  = e[7] ? m_cnt : (m_cnt + 1) % (1 << CW);
            if (m_mode == 1 && !mdu_done) begin
                n_wd = (m_wd < MAXC) ? m_wd + 1 : m_wd;
                n_to = m_to || (n_wd >= MAXC);
            end else begin
                n_wd = 0;
                n_to = m_to;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0;
            m_cnt  <= 0;
            m_wd   <= 0;
            m_to   <= 0;
        end else begin
            m_mode <= n_mode;
            m_cnt  <= n_cnt;
            m_wd   <= n_wd;
            m_to   <= n_to;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clr();
        id_rs1_idx  = 5'd0;
        id_rs2_idx  = 5'd0;
        ex_rd_idx   = 5'd0;
        id_rs1_used = 1'b0;
        id_rs2_used = 1'b0;
        ex_wben     = 1'b0;
        ex_is_load  = 1'b0;
        ex_redirect = 1'b0;
        ex_mdu_req  = 1'b0;
        mdu_done    = 1'b0;
        lsu_req     = 1'b0;
        lsu_ack     = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        #3;
        chk("rst_ctl", dut_ctl, C_NORM);
        chk("rst_state", hz.state_o, 0);
        chk("rst_cnt", hz.stall_cnt, 0);
        chk("rst_timeout", hz.mdu_timeout, 0);
        nxt();
        rst = 1'b0;

        // lw x5 in EX, ID reads x5 via rs2
        ex_is_load = 1; ex_wben = 1; ex_rd_idx = 5;
        id_rs2_idx = 5; id_rs2_used = 1; id_rs1_idx = 3; id_rs1_used = 1;
        #2 chk("ldu_ctl", dut_ctl, C_LDU);
        nxt();
        ex_is_load = 0;
        #2 chk("ldu_after_ctl", dut_ctl, C_NORM);
        chk("ldu_cnt", hz.stall_cnt, 1);
        nxt();

        // x0 destination never stalls; redirect suppresses ldu
        ex_is_load = 1; ex_rd_idx = 0; id_rs2_idx = 0;
        #2 chk("x0_ctl", dut_ctl, C_NORM);
        nxt();
        ex_rd_idx = 5; id_rs2_idx = 5; ex_redirect = 1;
        #2 chk("redir_ctl", dut_ctl, C_REDIR);
        nxt();
        clr();
        #2 chk("redir_cnt", hz.stall_cnt, 1);
        nxt();

        // MDU op, done in the 5th wait cycle
        ex_mdu_req = 1;
        #2 chk("mdu_enter_ctl", dut_ctl, C_MDU);
        nxt();
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) mdu_done = 1;
            #2 chk("mdu_state", hz.state_o, 1);
            chk("mdu_ctl", dut_ctl, (k == 5) ? C_NORM : C_MDU);
            nxt();
        end
        clr();
        #2 chk("mdu_exit_state", hz.state_o, 0);
        chk("mdu_cnt", hz.stall_cnt, 6);
        chk("mdu_timeout_sticky", hz.mdu_timeout, 1);
        nxt();

        // LSU wait with MDU pending behind it
        lsu_req = 1; ex_mdu_req = 1;
        #2 chk("memw_enter_ctl", dut_ctl, C_MEMW);
        nxt();
        for (int m = 1; m <= 3; m++) begin
            if (m == 3) lsu_ack = 1;
            #2 chk("memw_state", hz.state_o, 2);
            chk("memw_ctl", dut_ctl, (m == 3) ? C_MDU : C_MEMW);
            nxt();
        end
        lsu_req = 0; lsu_ack = 0; mdu_done = 1;
        #2 chk("memw_to_mdu_state", hz.state_o, 1);
        chk("memw_mdu_memwb", hz.memwb_en, 1);
        nxt();
        clr();
        #2 chk("memw_exit_state", hz.state_o, 0);
        chk("memw_cnt", hz.stall_cnt, 10);
        nxt();

        // stall counter wrap: 6 more stall cycles take 10 -> 16 -> 0
        ex_is_load = 1; ex_wben = 1; ex_rd_idx = 7;
        id_rs1_idx = 7; id_rs1_used = 1;
        for (int i = 0; i < 6; i++) begin
            #2;
            nxt();
        end
        clr();
        #2 chk("wrap_cnt", hz.stall_cnt, 0);
        nxt();

        // watchdog with mdu_done never arriving
        rst = 1'b1;
        #2 chk("wd_rst_timeout", hz.mdu_timeout, 0);
        nxt();
        rst = 1'b0;
        ex_mdu_req = 1;
        #2;
        nxt();
        for (int j = 1; j <= 6; j++) begin
            #2 chk("wd_state", hz.state_o, 1);
            chk("wd_timeout", hz.mdu_timeout, (j >= 5) ? 1 : 0);
            if (j < 6) nxt();
        end

        // asynchronous reset mid-wait
        #1 rst = 1'b1;
        #1;
        chk("arst_state", hz.state_o, 0);
        chk("arst_cnt", hz.stall_cnt, 0);
        chk("arst_timeout", hz.mdu_timeout, 0);
        clr();
        nxt();
        rst = 1'b0;
        #2 chk("arst_after_state", hz.state_o, 0);
        chk("arst_after_ctl", dut_ctl, C_NORM);
        nxt();
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
